// File: rtl/stream_source.sv
// -----------------------------------------------------------------------------
// stream_source
//   Generates one packet of arithmetic-progression data beats per start
//   request on a valid/ready stream. Beat i carries seed + i*step (mod 2^WIDTH).
//   An optional idle gap of `gap` cycles is inserted after every accepted
//   non-final beat.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : asynchronous active-low reset
//   start      : begin a packet (sampled only while idle)
//   len        : number of beats in the packet (0 = empty packet)
//   seed       : data value of the first beat
//   step       : increment applied after each accepted beat
//   gap        : idle cycles inserted after each accepted non-final beat
//   out_valid  : beat offered
//   out_ready  : downstream accepts the offered beat
//   out_data   : beat payload
//   out_last   : offered beat is the final beat of the packet
//   busy       : packet in progress (SEND or GAP)
//   done       : one-cycle completion pulse
//   beats_sent : handshakes completed in the current / most recent packet
// -----------------------------------------------------------------------------
module stream_source #(
    parameter int WIDTH = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       len,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] step,
    input  logic [GAP_W-1:0] gap,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic [7:0]       beats_sent
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_next;

    logic [7:0]       remaining;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] step_r;
    logic [GAP_W-1:0] gap_r;
    logic [GAP_W-1:0] gap_cnt;
    logic [7:0]       sent;
    logic             handshake;

    // out_valid is a pure decode of the state register, so the handshake
    // term never feeds back into any output combinationally.
    assign handshake = (state == SEND) && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len == 8'd0) ? DONE : SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_last  = (remaining == 8'd1);
                busy      = 1'b1;
                if (handshake) begin
                    if (remaining == 8'd1) begin
                        state_next = DONE;
                    end else if (gap_r != '0) begin
                        state_next = GAP;
                    end
                end
            end
            GAP: begin
                busy = 1'b1;
                // gap_cnt is loaded with the full gap, so leaving on 1
                // gives exactly gap_r cycles in this state.
                if (gap_cnt <= 1) begin
                    state_next = SEND;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remaining <= '0;
            data      <= '0;
            step_r    <= '0;
            gap_r     <= '0;
            gap_cnt   <= '0;
            sent      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= len;
                        data      <= seed;
                        step_r    <= step;
                        gap_r     <= gap;
                        sent      <= '0;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        remaining <= remaining - 8'd1;
                        sent      <= sent + 8'd1;
                        data      <= data + step_r;
                        gap_cnt   <= gap_r;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_data   = data;
    assign beats_sent = sent;

endmodule

// File: tb/tb_stream_source.sv
module tb_stream_source;

    localparam int WIDTH = 8;
    localparam int GAP_W = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [7:0]       len;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] step;
    logic [GAP_W-1:0] gap;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;
    logic             done;
    logic [7:0]       beats_sent;

    int errors = 0;
    int checks = 0;

    stream_source #(.WIDTH(WIDTH), .GAP_W(GAP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .seed      (seed),
        .step      (step),
        .gap       (gap),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .beats_sent(beats_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_last"},  32'(out_last),  32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_done"},  32'(done),      32'd0);
        chk({tag, "_data"},  32'(out_data),  32'd0);
        chk({tag, "_beats"}, 32'(beats_sent), 32'd0);
    endtask

    // Reference: beat i of a packet is seed + i*step mod 2^WIDTH, final beat
    // flagged last, exactly g idle cycles between consecutive beats, done once
    // right after the final acceptance. mode: 0 ready always, 1 random ready,
    // 2 ready low for 3 cycles while beat 1 is offered.
    task automatic run_packet(input int n, input logic [7:0] sd, input logic [7:0] st,
                              input logic [3:0] g, input int mode, input bit pulse);
        int  idx;
        int  zero_run;
        int  stall;
        bit  new_beat;
        bit  pulsed;
        bit  finished;
        logic [7:0] exp_d;
        start = 1'b1; len = 8'(n); seed = sd; step = st; gap = g; out_ready = 1'b0;
        tick();
        start = 1'b0;
        idx = 0; zero_run = 0; stall = 0; new_beat = 1'b0; pulsed = 1'b0; finished = 1'b0;
        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            start = 1'b0;
            if (out_valid) begin
                exp_d = sd + 8'(idx) * st;
                chk("data",  32'(out_data),   32'(exp_d));
                chk("last",  32'(out_last),   32'(idx == n - 1));
                chk("busy",  32'(busy),       32'd1);
                chk("sent",  32'(beats_sent), 32'(idx));
                if (new_beat) begin
                    chk("gap_len", 32'(zero_run), 32'(g));
                    new_beat = 1'b0;
                end
                zero_run = 0;
                case (mode)
                    0: out_ready = 1'b1;
                    1: out_ready = 1'($urandom_range(0, 1));
                    default: begin
                        if (idx == 1 && stall < 3) begin
                            out_ready = 1'b0;
                            stall++;
                        end else begin
                            out_ready = 1'b1;
                        end
                    end
                endcase
                if (out_ready) begin
                    idx++;
                    new_beat = (idx < n);
                end
                if (pulse && !pulsed && idx >= 1) begin
                    start  = 1'b1;
                    pulsed = 1'b1;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
                if (done) begin
                    chk("done_count", 32'(idx),      32'(n));
                    chk("done_gap",   32'(zero_run), 32'd0);
                    chk("done_busy",  32'(busy),     32'd0);
                    finished = 1'b1;
                end else begin
                    chk("gap_busy", 32'(busy), 32'd1);
                    zero_run++;
                end
            end
            // Scramble the parameter inputs: latched values must be used.
            len  = 8'($urandom);
            seed = 8'($urandom);
            step = 8'($urandom);
            gap  = 4'($urandom);
            tick();
        end
        start = 1'b0;
        chk("timeout",    32'(finished),   32'd1);
        chk("idle_done",  32'(done),       32'd0);
        chk("idle_busy",  32'(busy),       32'd0);
        chk("idle_valid", 32'(out_valid),  32'd0);
        chk("idle_sent",  32'(beats_sent), 32'(n));
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; len = '0; seed = '0; step = '0; gap = '0; out_ready = 1'b0;
        #3;
        chk_all_zero("reset");
        tick();
        tick();
        rst = 1'b1;

        // First start right after release, back-to-back beats
        run_packet(4, 8'h10, 8'h01, 4'd0, 0, 1'b0);
        // Back-pressure on beat 0x11
        run_packet(4, 8'h10, 8'h01, 4'd0, 2, 1'b0);
        // Wrap with gap of 2
        run_packet(3, 8'hFE, 8'h01, 4'd2, 0, 1'b0);
        // Empty packet
        run_packet(0, 8'h55, 8'h01, 4'd3, 0, 1'b0);
        // Start pulsed mid-packet is ignored
        run_packet(5, 8'h20, 8'h03, 4'd1, 1, 1'b1);
        // Maximum length
        run_packet(255, 8'h00, 8'h01, 4'd0, 0, 1'b0);

        // Randomized packets
        for (int p = 0; p < 8; p++) begin
            run_packet(int'($urandom_range(1, 12)), 8'($urandom), 8'($urandom),
                       4'($urandom_range(0, 3)), 1, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset mid-packet after 2 of 5 beats
        start = 1'b1; len = 8'd5; seed = 8'h40; step = 8'h03; gap = 4'd0; out_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre_rst_data", 32'(out_data), 32'h46);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_valid", 32'(out_valid), 32'd0);
            chk("post_rst_busy",  32'(busy),      32'd0);
        end
        run_packet(2, 8'h7F, 8'h80, 4'd1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_source.md
STREAM_SOURCE -- requirements
Module: stream_source

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the data beat width in bits.
REQ-002 The module SHALL have parameter GAP_W, default 4, giving the width of the inter-beat gap count.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-low; rst=0 resets immediately, and the release is synchronous to clk.
REQ-005 Port start, input, 1 bit: request to begin one packet; sampled only in IDLE.
REQ-006 Port len, input, 8 bits: number of beats in the packet.
REQ-007 Port seed, input, WIDTH bits: data value of the first beat.
REQ-008 Port step, input, WIDTH bits: increment added to the data value after each accepted beat.
REQ-009 Port gap, input, GAP_W bits: number of idle cycles inserted after each accepted non-final beat.
REQ-010 Port out_valid, output, 1 bit: a beat is offered.
REQ-011 Port out_ready, input, 1 bit: the downstream consumer accepts the beat.
REQ-012 Port out_data, output, WIDTH bits: beat payload.
REQ-013 Port out_last, output, 1 bit: the offered beat is the final beat of the packet.
REQ-014 Port busy, output, 1 bit: a packet is in progress.
REQ-015 Port done, output, 1 bit: one-cycle completion pulse.
REQ-016 Port beats_sent, output, 8 bits: number of handshakes completed in the current or most recent packet.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, SEND, GAP, DONE.
REQ-018 In IDLE with start=1 and len!=0, the block SHALL latch len, seed, step and gap, clear beats_sent, and enter SEND on the next cycle.
REQ-019 In IDLE with start=1 and len=0, the block SHALL enter DONE without asserting out_valid.
REQ-020 In IDLE, start is sampled as described above; in SEND, GAP and DONE, start SHALL be ignored and latched parameters SHALL NOT change.
REQ-021 In SEND, out_valid SHALL be 1; in IDLE, GAP and DONE, out_valid SHALL be 0.
REQ-022 out_valid, out_data and out_last SHALL be driven from registers only, with no combinational path from out_ready.
REQ-023 A handshake SHALL occur when out_valid=1 and out_ready=1 are seen at the same rising edge.
REQ-024 While out_valid=1 and out_ready=0, out_data and out_last SHALL remain stable, and out_valid SHALL NOT drop before the handshake.
REQ-025 On each handshake, remaining beats SHALL decrement, beats_sent SHALL increment, and the data value SHALL become data+step modulo 2^WIDTH (wrap, no saturation).
REQ-026 out_last SHALL be 1 exactly when the remaining beat count equals 1.
REQ-027 On a handshake of the last beat, the FSM SHALL go to DONE.
REQ-028 On a handshake of a non-last beat with gap=0, the FSM SHALL stay in SEND and present the next beat in the following cycle (back-to-back).
REQ-029 On a handshake of a non-last beat with gap=G>0, the FSM SHALL spend exactly G cycles in GAP with out_valid=0, then return to SEND.
REQ-030 In DONE, done SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE; start in that following IDLE cycle SHALL be accepted.
REQ-031 busy SHALL be 1 in SEND and GAP, and 0 in IDLE and DONE.
REQ-032 beats_sent SHALL hold its value after DONE until the next accepted start.
REQ-033 A packet with len=255 SHALL deliver exactly 255 beats; the beat counter SHALL NOT overflow.

Reset
REQ-034 While rst=0, the state SHALL be IDLE and out_valid, out_last, busy, done, out_data and beats_sent SHALL all be 0, independent of clk.
REQ-035 Reset asserted mid-packet SHALL abort the packet immediately; after release, no remaining beats of the aborted packet SHALL be emitted.
REQ-036 The first start SHALL be sampled on the first rising edge after rst is released.

Verification
REQ-037 len=4, seed=0x10, step=1, gap=0, out_ready=1 -> out_data 0x10, 0x11, 0x12, 0x13 on 4 consecutive cycles; out_last only with 0x13; done on the next cycle; beats_sent=4.
REQ-038 Same stimulus with out_ready=0 for 3 cycles while 0x11 is offered -> 0x11 held with out_valid=1 for 4 cycles; total packet of 4 beats unchanged.
REQ-039 len=3, seed=0xFE, step=1, gap=2 -> beats 0xFE, 0xFF, 0x00 (wrap), each separated by exactly 2 out_valid=0 cycles.
REQ-040 start with len=0 -> no out_valid; done pulse 1 cycle; busy stays 0; beats_sent=0.
REQ-041 Pulse start again during SEND with different seed -> ignored; packet completes with the original parameters.
REQ-042 rst driven low after 2 of 5 beats -> outputs go to 0 without waiting for a clock edge; after release, out_valid stays 0 until a new start.
